// File: rtl/inst_axi_rd_bridge.sv
// Read-only bridge from the IF stage's SRAM-like fetch port to a single-beat AXI AR/R master.
// Requests are accepted one at a time; data returns in AXI order, one data_ok per accepted request.
module inst_axi_rd_bridge #(
    parameter logic [3:0]  ARID      = 4'd0,
    parameter int unsigned MAX_OUTST = 2
) (
    input  logic        clk,
    input  logic        reset,

    input  logic        inst_sram_req,
    input  logic        inst_sram_wr,
    input  logic [1:0]  inst_sram_size,
    input  logic [31:0] inst_sram_addr,
    output logic        inst_sram_addr_ok,
    output logic        inst_sram_data_ok,
    output logic [31:0] inst_sram_rdata,

    output logic [3:0]  arid,
    output logic [31:0] araddr,
    output logic [7:0]  arlen,
    output logic [2:0]  arsize,
    output logic [1:0]  arburst,
    output logic [1:0]  arlock,
    output logic [3:0]  arcache,
    output logic [2:0]  arprot,
    output logic        arvalid,
    input  logic        arready,

    input  logic [3:0]  rid,
    input  logic [31:0] rdata,
    input  logic [1:0]  rresp,
    input  logic        rlast,
    input  logic        rvalid,
    output logic        rready
);

    localparam logic [2:0] MaxOutst = 3'(MAX_OUTST);

    typedef enum logic [0:0] {ArIdle, ArSend} ar_state_e;

    ar_state_e  ar_state;
    logic [2:0] cnt;
    logic       beat_hit;
    logic       unused_r;

    assign arid     = ARID;
    assign arlen    = 8'd0;
    assign arburst  = 2'b01;
    assign arlock   = 2'b00;
    assign arcache  = 4'd0;
    assign arprot   = 3'd0;
    assign rready   = 1'b1;
    assign unused_r = ^{rresp, rlast};

    // Gated by reset so no request is ever accepted while the bridge is being cleared.
    assign inst_sram_addr_ok = ~reset & (ar_state == ArIdle) & inst_sram_req & ~inst_sram_wr
                             & (cnt < MaxOutst);

    // Beats arriving with nothing outstanding belong to reads issued before a reset.
    assign beat_hit = rvalid & rready & (rid == ARID) & (cnt != 3'd0);

    always_ff @(posedge clk) begin
        if (reset) begin
            ar_state <= ArIdle;
            arvalid  <= 1'b0;
            araddr   <= 32'd0;
            arsize   <= 3'd0;
        end else begin
            case (ar_state)
                ArIdle: begin
                    if (inst_sram_addr_ok) begin
                        araddr   <= inst_sram_addr;
                        arsize   <= {1'b0, inst_sram_size};
                        arvalid  <= 1'b1;
                        ar_state <= ArSend;
                    end
                end
                ArSend: begin
                    if (arready) begin
                        arvalid  <= 1'b0;
                        ar_state <= ArIdle;
                    end
                end
                default: begin
                    arvalid  <= 1'b0;
                    ar_state <= ArIdle;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt <= 3'd0;
        end else begin
            case ({inst_sram_addr_ok, beat_hit})
                2'b10:   cnt <= cnt + 3'd1;
                2'b01:   cnt <= cnt - 3'd1;
                default: cnt <= cnt;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            inst_sram_data_ok <= 1'b0;
            inst_sram_rdata   <= 32'd0;
        end else begin
            inst_sram_data_ok <= beat_hit;
            if (beat_hit) begin
                inst_sram_rdata <= rdata;
            end
        end
    end

endmodule
